// File: rtl/branch_predictor.sv
// Gshare branch predictor: 2-bit saturating counter BHT indexed by PC (optionally XOR
// global history), trained non-speculatively from MEM, initialised by a post-reset sweep.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 4,
  parameter bit GHR_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           offset,
  input  logic                  branch_decode_sig,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [31:0]           branch_addr,
  output logic                  init_done
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [INDEX_BITS-1:0] sweep;
  logic [GHR_BITS-1:0]   ghr;
  logic [GHR_BITS-1:0]   ghr_next;
  logic [1:0]            bht [ENTRIES];

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_addr;
  logic [1:0]            wr_data;
  logic [1:0]            cur;

  assign pc_idx  = in_addr[INDEX_BITS+1:2];
  assign ghr_ext = INDEX_BITS'(ghr);

  generate
    if (GHR_BITS > 1) begin : g_shift
      assign ghr_next = {ghr[GHR_BITS-2:0], upd_taken};
    end else begin : g_single
      assign ghr_next = upd_taken;
    end
  endgenerate

  always_comb begin
    pred_index  = GHR_ENABLE ? (pc_idx ^ ghr_ext) : pc_idx;
    prediction  = bht[pred_index][1] & branch_decode_sig & init_done;
    branch_addr = in_addr + offset;
  end

  // Single write port: the init sweep owns it in INIT, training owns it in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep;
    wr_data = 2'b01;
    cur     = bht[upd_index];
    if (!reset) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (upd_valid) begin
        wr_en   = 1'b1;
        wr_addr = upd_index;
        if (upd_taken) wr_data = (cur == 2'b11) ? cur : cur + 2'd1;
        else           wr_data = (cur == 2'b00) ? cur : cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) bht[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep     <= '0;
      ghr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (upd_valid) ghr <= ghr_next;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: gshare and bimodal instances side by side, checked against
// an array-of-counters reference model with integer history.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_addr, offset;
  logic        bd, uv, ut;
  logic [5:0]  ui;

  logic        pred_g, done_g, pred_b, done_b;
  logic [5:0]  idx_g, idx_b;
  logic [31:0] baddr_g, baddr_b;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int ctr [64];
  int hist  = 0;
  int swept = 0;
  bit done  = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(4), .GHR_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .offset(offset),
    .branch_decode_sig(bd), .upd_valid(uv), .upd_index(ui), .upd_taken(ut),
    .prediction(pred_g), .pred_index(idx_g), .branch_addr(baddr_g), .init_done(done_g));

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(4), .GHR_ENABLE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_addr(in_addr), .offset(offset),
    .branch_decode_sig(bd), .upd_valid(uv), .upd_index(ui), .upd_taken(ut),
    .prediction(pred_b), .pred_index(idx_b), .branch_addr(baddr_b), .init_done(done_b));

  function automatic int m_pc(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic logic [79:0] exp_outs();
    int pc, ig;
    logic [31:0] ba;
    logic pg, pb;
    pc = m_pc(in_addr);
    ig = pc ^ hist;
    ba = in_addr + offset;
    pg = done && bd && (ctr[ig] >= 2);
    pb = done && bd && (ctr[pc] >= 2);
    return {pg, 6'(ig), ba, done, pb, 6'(pc), ba, done};
  endfunction

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] o,
                       input logic b, input logic u, input logic [5:0] i, input logic t);
    reset = r; in_addr = a; offset = o; bd = b; uv = u; ui = i; ut = t;
    #1;
  endtask

  // Advance the model by the edge about to happen, then move to the next sample point.
  task automatic tick();
    if (reset) begin
      done = 1'b0; swept = 0; hist = 0;
    end else if (!done) begin
      swept++;
      if (swept == 64) begin
        done = 1'b1;
        foreach (ctr[k]) ctr[k] = 1;
      end
    end else if (uv) begin
      if (ut) ctr[ui] = (ctr[ui] == 3) ? 3 : ctr[ui] + 1;
      else    ctr[ui] = (ctr[ui] == 0) ? 0 : ctr[ui] - 1;
      hist = (hist * 2 + int'(ut)) % 16;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b1, 6'd4, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({done_g, done_b, pred_g, pred_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_state: got done/pred %b required 0000", {done_g, done_b, pred_g, pred_b});
    end
  endtask

  task automatic test_init();
    for (int c = 1; c <= 64; c++) begin
      drive(1'b0, $urandom, $urandom, 1'b1, 1'($urandom_range(1)), 6'($urandom), 1'($urandom_range(1)));
      n_cmp++;
      if ({pred_g, idx_g, baddr_g, done_g, pred_b, idx_b, baddr_b, done_b} !== exp_outs()) begin
        n_bad++;
        $display("FAIL init_cycle_%0d: got %h required %h", c,
                 {pred_g, idx_g, baddr_g, done_g, pred_b, idx_b, baddr_b, done_b}, exp_outs());
      end
      tick();
    end
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({done_g, done_b, idx_g} !== {2'b11, 6'd4}) begin
      n_bad++;
      $display("FAIL init_done_cycle_65: got done %b%b idx %0d required 11 idx 4", done_g, done_b, idx_g);
    end
  endtask

  task automatic test_bimodal();
    bit ts [8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    bit pre [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({idx_b, pred_b} !== {6'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL bimodal_start: got idx %0d pred %b required idx 4 pred 0", idx_b, pred_b);
    end
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 6'd4, ts[s]);
      n_cmp++;
      if (pred_b !== pre[s]) begin
        n_bad++;
        $display("FAIL bimodal_step_%0d: got pred %b required %b", s, pred_b, pre[s]);
      end
      tick();
    end
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (pred_b !== 1'b0 || {pred_g, idx_g, baddr_g, done_g, pred_b, idx_b, baddr_b, done_b} !== exp_outs()) begin
      n_bad++;
      $display("FAIL bimodal_end: got %h required %h", {pred_g, idx_g, baddr_g, done_g}, exp_outs());
    end
  endtask

  task automatic test_gshare();
    bit pat [4] = '{1, 0, 1, 1};
    foreach (pat[k]) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd40, pat[k]);
      tick();
    end
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({idx_g, idx_b} !== {6'd15, 6'd4}) begin
      n_bad++;
      $display("FAIL gshare_index: got %0d/%0d required 15/4", idx_g, idx_b);
    end
  endtask

  task automatic test_hazard();
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 6'd15, 1'b1);
    n_cmp++;
    if ({idx_g, pred_g} !== {6'd15, 1'b0}) begin
      n_bad++;
      $display("FAIL hazard_same_cycle: got idx %0d pred %b required idx 15 pred 0", idx_g, pred_g);
    end
    tick();
    // history is now 0111, so PC index 8 maps back to entry 15
    drive(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({idx_g, pred_g} !== {6'd15, 1'b1}) begin
      n_bad++;
      $display("FAIL hazard_next_cycle: got idx %0d pred %b required idx 15 pred 1", idx_g, pred_g);
    end
  endtask

  task automatic test_branch_addr();
    logic [31:0] a, o;
    drive(1'b0, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (baddr_g !== 32'h10) begin
      n_bad++;
      $display("FAIL baddr_wrap: got %h required 00000010", baddr_g);
    end
    drive(1'b0, 32'h100, 32'hFFFF_FFF8, 1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (baddr_b !== 32'hF8) begin
      n_bad++;
      $display("FAIL baddr_negative: got %h required 000000f8", baddr_b);
    end
    for (int k = 0; k < 20; k++) begin
      a = $urandom; o = $urandom;
      drive(1'b0, a, o, 1'b0, 1'b0, 6'd0, 1'b0);
      n_cmp++;
      if (baddr_g !== a + o) begin
        n_bad++;
        $display("FAIL baddr_random_%0d: got %h required %h", k, baddr_g, a + o);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [5:0]  i;
    for (int k = 0; k < 600; k++) begin
      a = $urandom;
      i = $urandom_range(1) ? 6'(m_pc(a)) : 6'($urandom);
      drive(1'(($urandom % 150) == 0), a, $urandom, 1'($urandom_range(3) != 0),
            1'($urandom_range(1)), i, 1'($urandom_range(1)));
      n_cmp++;
      if ({pred_g, idx_g, baddr_g, done_g, pred_b, idx_b, baddr_b, done_b} !== exp_outs()) begin
        n_bad++;
        $display("FAIL random_%0d: got %h required %h", k,
                 {pred_g, idx_g, baddr_g, done_g, pred_b, idx_b, baddr_b, done_b}, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_reset_run();
    for (int k = 0; k < 70; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, (k < 2) ? 6'd4 : 6'd15, 1'b1);
      tick();
    end
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (pred_b !== 1'b1 || done_g !== 1'b1) begin
      n_bad++;
      $display("FAIL trained_before_reset: got pred %b done %b required 1 1", pred_b, done_g);
    end
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({done_g, done_b, idx_g, pred_g} !== {2'b00, 6'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_in_run: got done %b%b idx %0d pred %b required 00 idx 4 pred 0",
               done_g, done_b, idx_g, pred_g);
    end
    for (int k = 0; k < 64; k++) tick();
    drive(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({done_g, idx_g, pred_g, pred_b} !== {1'b1, 6'd4, 2'b00}) begin
      n_bad++;
      $display("FAIL reinit_entry4: got done %b idx %0d pred %b%b required 1 4 00", done_g, idx_g, pred_g, pred_b);
    end
    drive(1'b0, 32'h3C, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if ({idx_g, pred_g, pred_b} !== {6'd15, 2'b00}) begin
      n_bad++;
      $display("FAIL reinit_entry15: got idx %0d pred %b%b required 15 00", idx_g, pred_g, pred_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_bimodal();
    test_gshare();
    test_hazard();
    test_branch_addr();
    test_random();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
